// File: rtl/wiring_pkg.sv
// Shared types and helpers for the Wiring step sequencer.
package wiring_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LRST,
    FIRE,
    WAIT,
    RESP
  } seq_state_e;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/wiring_settle_detect.sv
// Counts consecutive idle cycles of the Wiring network; settled is asserted combinationally
// on the cycle that completes the SETTLE_CYCLES-long idle run.
module wiring_settle_detect
  import wiring_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic running,
  output logic settled
);

  localparam int IW = cnt_width(SETTLE_CYCLES);

  logic [IW-1:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear || running) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IW'(SETTLE_CYCLES)) begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end

  // Current idle cycle counts toward the run, so settle fires without an extra cycle of lag.
  assign settled = !running && (idle_cnt >= IW'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/wiring_step_sequencer.sv
// Drives one trigger vector through the Wiring block and reports the settled result.
// state | meaning
// IDLE  | ready for a request
// LRST  | pulse Wiring logic_reset
// FIRE  | drive latched vector onto Wiring in for one cycle
// WAIT  | count cycles until settled or budget exhausted
// RESP  | hold result until consumer accepts
module wiring_step_sequencer
  import wiring_pkg::*;
#(
  parameter int INPUT_WIDTH   = 3,
  parameter int OUTPUT_WIDTH  = 1,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_CYCLES    = 1024,
  localparam int CW = cnt_width(MAX_CYCLES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [INPUT_WIDTH-1:0]  req_in,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [OUTPUT_WIDTH-1:0] resp_out,
  output logic [CW-1:0]           resp_cycles,
  output logic                    resp_timeout,
  output logic                    wiring_logic_reset,
  output logic [INPUT_WIDTH-1:0]  wiring_in,
  input  logic                    wiring_running,
  input  logic [OUTPUT_WIDTH-1:0] wiring_out
);

  seq_state_e state, state_next;

  logic [INPUT_WIDTH-1:0]  vec;
  logic [CW-1:0]           cyc;
  logic [OUTPUT_WIDTH-1:0] out_q;
  logic [CW-1:0]           cycles_q;
  logic                    timeout_q;
  logic                    settled;
  logic                    timed_out;
  logic                    settle_clear;

  assign settle_clear = (state != WAIT);
  assign timed_out    = (cyc == CW'(MAX_CYCLES));

  wiring_settle_detect #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk     (clk),
    .reset   (reset),
    .clear   (settle_clear),
    .running (wiring_running),
    .settled (settled)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vec       <= '0;
      cyc       <= '0;
      out_q     <= '0;
      cycles_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        vec <= req_in;
      end
      // cyc holds the number of the current WAIT cycle, starting at 1.
      if (state == FIRE) begin
        cyc <= CW'(1);
      end else if (state == WAIT && !timed_out) begin
        cyc <= cyc + CW'(1);
      end
      if (state == WAIT && (settled || timed_out)) begin
        out_q     <= settled ? wiring_out : '0;
        cycles_q  <= cyc;
        timeout_q <= !settled;
      end
    end
  end

  always_comb begin
    state_next         = state;
    req_ready          = 1'b0;
    resp_valid         = 1'b0;
    wiring_logic_reset = 1'b0;
    wiring_in          = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = LRST;
      end
      LRST: begin
        wiring_logic_reset = 1'b1;
        state_next         = FIRE;
      end
      FIRE: begin
        wiring_in  = vec;
        state_next = WAIT;
      end
      WAIT: begin
        if (settled || timed_out) state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign resp_out     = out_q;
  assign resp_cycles  = cycles_q;
  assign resp_timeout = timeout_q;

endmodule

// File: tb/tb_wiring_step_sequencer.sv
// Scoreboard bench for wiring_step_sequencer driving a behavioural XOR Wiring model.
module tb_wiring_step_sequencer;

  localparam int IW = 3;
  localparam int OW = 1;
  localparam int SC = 2;
  localparam int MC = 16;
  localparam int CW = $clog2(MC + 1);
  localparam int K  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [IW-1:0] req_in = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [OW-1:0] resp_out;
  logic [CW-1:0] resp_cycles;
  logic          resp_timeout;
  logic          wiring_logic_reset;
  logic [IW-1:0] wiring_in;
  logic          wiring_running;
  logic [OW-1:0] wiring_out;

  logic          force_busy = 1'b0;
  int            run_cnt;
  logic          m_out;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic          o;
    logic [CW-1:0] c;
    logic          t;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  wiring_step_sequencer #(
    .INPUT_WIDTH  (IW),
    .OUTPUT_WIDTH (OW),
    .SETTLE_CYCLES(SC),
    .MAX_CYCLES   (MC)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_in            (req_in),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_out          (resp_out),
    .resp_cycles       (resp_cycles),
    .resp_timeout      (resp_timeout),
    .wiring_logic_reset(wiring_logic_reset),
    .wiring_in         (wiring_in),
    .wiring_running    (wiring_running),
    .wiring_out        (wiring_out)
  );

  // Wiring model: out = XOR of the trigger, running high for K cycles after a trigger.
  always @(posedge clk) begin
    if (reset || wiring_logic_reset) begin
      run_cnt <= 0;
      m_out   <= 1'b0;
    end else if (wiring_in != '0) begin
      run_cnt <= K;
      m_out   <= ^wiring_in;
    end else if (run_cnt != 0) begin
      run_cnt <= run_cnt - 1;
    end
  end

  assign wiring_running = (run_cnt != 0) || force_busy;
  assign wiring_out     = m_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!reset && resp_valid && resp_ready) begin
      exp_t e;
      chk("sb_nonempty", 32'(sb.size() != 0), 32'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("resp_out", 32'(resp_out), 32'(e.o));
        chk("resp_cycles", 32'(resp_cycles), 32'(e.c));
        chk("resp_timeout", 32'(resp_timeout), 32'(e.t));
      end
    end
  end

  // Entered just after a posedge; returns just after the response handshake edge.
  task automatic run_req(input logic [IW-1:0] vec, input logic eo, input int ec,
                         input logic et, input bit hold);
    int k;
    sb.push_back('{o: eo, c: CW'(ec), t: et});
    req_in     = vec;
    req_valid  = 1'b1;
    resp_ready = !hold;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'(1));
    chk("idle_no_resp", 32'(resp_valid), 32'(0));
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    @(negedge clk);
    chk("lrst_pulse", 32'(wiring_logic_reset), 32'(1));
    chk("lrst_in_zero", 32'(wiring_in), 32'(0));
    chk("busy_ready", 32'(req_ready), 32'(0));
    @(negedge clk);
    chk("fire_in", 32'(wiring_in), 32'(vec));
    chk("fire_lrst_low", 32'(wiring_logic_reset), 32'(0));
    @(negedge clk);
    chk("pulse_end", 32'(wiring_in), 32'(0));
    k = 3;
    while (!resp_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), 32'(3 + ec));
    if (!resp_valid) begin
      sb.delete();
      return;
    end
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        chk("hold_valid", 32'(resp_valid), 32'(1));
        chk("hold_req_ready", 32'(req_ready), 32'(0));
        chk("hold_out", 32'(resp_out), 32'(eo));
        chk("hold_cycles", 32'(resp_cycles), 32'(ec));
        @(posedge clk);
        #1;
        if (i == 4) resp_ready = 1'b1;
        @(negedge clk);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'(1));
    chk("rst_resp_valid", 32'(resp_valid), 32'(0));
    chk("rst_lrst", 32'(wiring_logic_reset), 32'(0));
    chk("rst_in", 32'(wiring_in), 32'(0));
    chk("rst_resp_cycles", 32'(resp_cycles), 32'(0));
    @(posedge clk);
    #1;

    run_req(3'b111, 1'b1, 6, 1'b0, 1'b0);
    run_req(3'b011, 1'b0, 6, 1'b0, 1'b0);
    run_req(3'b001, 1'b1, 6, 1'b0, 1'b0);
    run_req(3'b000, 1'b0, SC, 1'b0, 1'b0);

    force_busy = 1'b1;
    run_req(3'b100, 1'b0, MC, 1'b1, 1'b0);
    force_busy = 1'b0;

    run_req(3'b111, 1'b1, 6, 1'b0, 1'b1);
    run_req(3'b111, 1'b1, 6, 1'b0, 1'b0);

    // Abort mid-WAIT with a two-cycle reset; no response may follow.
    force_busy = 1'b1;
    req_in     = 3'b101;
    req_valid  = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    force_busy = 1'b0;
    @(negedge clk);
    chk("abort_req_ready", 32'(req_ready), 32'(1));
    chk("abort_resp_valid", 32'(resp_valid), 32'(0));
    chk("abort_lrst", 32'(wiring_logic_reset), 32'(0));
    chk("abort_in", 32'(wiring_in), 32'(0));
    chk("abort_timeout", 32'(resp_timeout), 32'(0));
    repeat (25) @(negedge clk);
    chk("abort_stays_idle", 32'(resp_valid), 32'(0));
    @(posedge clk);
    #1;

    run_req(3'b110, 1'b0, 6, 1'b0, 1'b0);

    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
